// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: memory-port and decode-side signals of the fetch stage
interface if_prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);
  logic [ADDR_W-1:0] Branch_PC;
  logic              IsBranchTaken;
  logic              Insn_Ready;
  logic              Insn_Valid;
  logic [INSN_W-1:0] Instruction;
  logic [ADDR_W-1:0] PC_Current;
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [INSN_W-1:0] Mem_RData;
  modport master (
    input  Branch_PC, IsBranchTaken, Insn_Ready, Mem_Ack, Mem_RData,
    output Insn_Valid, Instruction, PC_Current, Mem_Req, Mem_Addr
  );
  modport slave (
    output Branch_PC, IsBranchTaken, Insn_Ready, Mem_Ack, Mem_RData,
    input  Insn_Valid, Instruction, PC_Current, Mem_Req, Mem_Addr
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: SimpleRisc fetch stage with a DEPTH-entry prefetch queue; define IF_PERF_CNT_EN to add Fetch_Count/Flush_Count
module if_prefetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic Clk,
  input logic Reset,
  if_prefetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Flush_Count
`endif
);
  localparam int STEP = INSN_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d, addr_d, tgt, base, next_pc;
  logic req_d;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [INSN_W-1:0] insn_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_d;
  logic redirect, push, pop, room;
  assign redirect = bus.IsBranchTaken;
  assign push = state == REQ && bus.Mem_Ack && !redirect;
  assign pop = bus.Insn_Valid && bus.Insn_Ready && !redirect;
  assign count_d = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign room = count_d < CNT_W'(DEPTH);
  assign tgt = bus.Branch_PC & ~ADDR_W'(STEP - 1);
  assign base = redirect ? tgt : fetch_pc;
  assign next_pc = fetch_pc + ADDR_W'(STEP);
  assign bus.Insn_Valid = count != '0;
  assign bus.Instruction = insn_q[rd_ptr];
  assign bus.PC_Current = pc_q[rd_ptr];
  // fetch sequencer: next state, request strobe, request address and fetch PC
  always_comb begin
    state_d = state;
    req_d = bus.Mem_Req;
    addr_d = bus.Mem_Addr;
    fetch_pc_d = base;
    if (state == IDLE) begin
      if (redirect || room) begin
        state_d = REQ;
        req_d = 1'b1;
        addr_d = base;
      end
    end else if (state == REQ) begin
      if (bus.Mem_Ack && !redirect) begin
        fetch_pc_d = next_pc;
        addr_d = room ? next_pc : bus.Mem_Addr;
        req_d = room;
        state_d = room ? REQ : IDLE;
      end else if (bus.Mem_Ack) begin
        addr_d = base;
      end else if (redirect) begin
        state_d = DISCARD;
      end
    end else if (bus.Mem_Ack) begin
      state_d = REQ;
      addr_d = base;
    end
  end
  // sequencer registers; reset drops the request at once
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      bus.Mem_Req <= 1'b0;
      bus.Mem_Addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_d;
      bus.Mem_Req <= req_d;
      bus.Mem_Addr <= addr_d;
      fetch_pc <= fetch_pc_d;
    end
  end
  // prefetch queue: a redirect empties it by snapping the read pointer to the write pointer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        insn_q[i] <= '0;
      end
    end else begin
      count <= count_d;
      if (redirect) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) begin
        pc_q[wr_ptr] <= bus.Mem_Addr;
        insn_q[wr_ptr] <= bus.Mem_RData;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  // fetch and redirect event counters, free-running modulo 2^32
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Fetch_Count <= '0;
      Flush_Count <= '0;
    end else begin
      Fetch_Count <= Fetch_Count + 32'(push);
      Flush_Count <= Flush_Count + 32'(redirect);
    end
  end
`endif
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: scoreboard bench for the prefetch unit against a byte-pattern memory with configurable latency
module tb_if_prefetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br = 1'b0;
  logic ready = 1'b0;
  logic [31:0] br_pc = '0;
  int lat = 0;
  int wait_cnt;
  int ack_cnt;
  int checks = 0;
  int passed = 0;
  typedef struct packed {logic [31:0] pc; logic [31:0] insn;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  if_prefetch_unit_if #(.ADDR_W(32), .INSN_W(32)) bus ();
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif
  if_prefetch_unit #(.ADDR_W(32), .INSN_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
`ifdef IF_PERF_CNT_EN
    ,
    .Fetch_Count(fetch_count),
    .Flush_Count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction
  assign bus.Branch_PC = br_pc;
  assign bus.IsBranchTaken = br;
  assign bus.Insn_Ready = ready;
  assign bus.Mem_Ack = bus.Mem_Req && wait_cnt >= lat;
  assign bus.Mem_RData = mem_word(bus.Mem_Addr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      ack_cnt <= 0;
    end else begin
      wait_cnt <= (bus.Mem_Req && !bus.Mem_Ack) ? wait_cnt + 1 : 0;
      if (bus.Mem_Req && bus.Mem_Ack) ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic test_reset;
    rst = 1'b1; ready = 1'b0; br = 1'b0; lat = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.Mem_Req !== 1'b0) $display("FAIL reset_mem_req got %0b exp 0", bus.Mem_Req); else passed++;
    checks++; if (bus.Mem_Addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", bus.Mem_Addr); else passed++;
    checks++; if (bus.Insn_Valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", bus.Insn_Valid); else passed++;
    checks++; if (bus.Instruction !== 32'h0) $display("FAIL reset_insn got %h exp 0", bus.Instruction); else passed++;
    checks++; if (bus.PC_Current !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.PC_Current); else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({bus.Insn_Valid, bus.Mem_Req} !== 2'b11) $display("FAIL pre_reset_busy got %b exp 11", {bus.Insn_Valid, bus.Mem_Req}); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.Mem_Req !== 1'b0) $display("FAIL async_reset_req got %0b exp 0", bus.Mem_Req); else passed++;
    checks++; if (bus.Insn_Valid !== 1'b0) $display("FAIL async_reset_valid got %0b exp 0", bus.Insn_Valid); else passed++;
    lat = 1000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({bus.Mem_Req, bus.Mem_Addr} !== {1'b1, 32'h0}) $display("FAIL first_req got %b/%h exp 1/00000000", bus.Mem_Req, bus.Mem_Addr); else passed++;
  endtask

  task automatic test_stream;
    int gaps;
    bit started;
    rst = 1'b1; lat = 0; ready = 1'b0; br = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h03020100});
    exp_q.push_back({32'h4, 32'h07060504});
    exp_q.push_back({32'h8, 32'h0B0A0908});
    for (int a = 12; a < 24; a += 4) exp_q.push_back({32'(a), mem_word(32'(a))});
    rst = 1'b0; ready = 1'b1; gaps = 0; started = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.Insn_Valid) begin
        started = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.PC_Current !== e.pc) $display("FAIL stream_pc got %h exp %h", bus.PC_Current, e.pc); else passed++;
        checks++; if (bus.Instruction !== e.insn) $display("FAIL stream_insn got %h exp %h", bus.Instruction, e.insn); else passed++;
      end else if (started) gaps++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL stream_timeout left %0d exp 0", exp_q.size()); else passed++;
    checks++; if (gaps != 0) $display("FAIL stream_gaps got %0d exp 0", gaps); else passed++;
  endtask

  task automatic test_backpressure;
    rst = 1'b1; lat = 0; ready = 1'b0; br = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (ack_cnt != 4) $display("FAIL bp_pushes got %0d exp 4", ack_cnt); else passed++;
    checks++; if (bus.Mem_Req !== 1'b0) $display("FAIL bp_req got %0b exp 0", bus.Mem_Req); else passed++;
    checks++; if (bus.Mem_Addr !== 32'hC) $display("FAIL bp_addr got %h exp 0000000c", bus.Mem_Addr); else passed++;
    checks++; if ({bus.Insn_Valid, bus.PC_Current, bus.Instruction} !== {1'b1, 32'h0, 32'h03020100}) $display("FAIL bp_head got %b/%h/%h exp 1/00000000/03020100", bus.Insn_Valid, bus.PC_Current, bus.Instruction); else passed++;
    exp_q.delete();
    for (int a = 0; a < 24; a += 4) exp_q.push_back({32'(a), mem_word(32'(a))});
    ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (c == 1) begin
        checks++; if ({bus.Mem_Req, bus.Mem_Addr} !== {1'b1, 32'h10}) $display("FAIL bp_resume got %b/%h exp 1/00000010", bus.Mem_Req, bus.Mem_Addr); else passed++;
      end
      if (bus.Insn_Valid) begin
        e = exp_q.pop_front();
        checks++; if ({bus.PC_Current, bus.Instruction} !== {e.pc, e.insn}) $display("FAIL bp_head_seq got %h/%h exp %h/%h", bus.PC_Current, bus.Instruction, e.pc, e.insn); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL bp_timeout left %0d exp 0", exp_q.size()); else passed++;
  endtask

  task automatic test_redirect_latency;
    bit found;
    bit seen_new;
    rst = 1'b1; lat = 3; ready = 1'b1; br = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h03020100});
    rst = 1'b0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      #1;
      if (bus.Mem_Req && bus.Mem_Addr == 32'h8) found = 1'b1;
      else if (bus.Insn_Valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if ({bus.PC_Current, bus.Instruction} !== {e.pc, e.insn}) $display("FAIL lat_head got %h/%h exp %h/%h", bus.PC_Current, bus.Instruction, e.pc, e.insn); else passed++;
      end
    end
    checks++; if (!found || exp_q.size() != 0) $display("FAIL lat_reach_8 found %0b left %0d exp 1/0", found, exp_q.size()); else passed++;
    br = 1'b1; br_pc = 32'h100;
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (bus.Insn_Valid !== 1'b0) $display("FAIL lat_flush got %0b exp 0", bus.Insn_Valid); else passed++;
    checks++; if ({bus.Mem_Req, bus.Mem_Addr} !== {1'b1, 32'h8}) $display("FAIL lat_discard_hold got %b/%h exp 1/00000008", bus.Mem_Req, bus.Mem_Addr); else passed++;
    exp_q.push_back({32'h100, 32'h03020100});
    exp_q.push_back({32'h104, 32'h07060504});
    seen_new = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
      if (!seen_new && bus.Mem_Addr != 32'h8) begin
        seen_new = 1'b1;
        checks++; if (bus.Mem_Addr !== 32'h100) $display("FAIL lat_next_addr got %h exp 00000100", bus.Mem_Addr); else passed++;
      end
      if (bus.Insn_Valid) begin
        e = exp_q.pop_front();
        checks++; if ({bus.PC_Current, bus.Instruction} !== {e.pc, e.insn}) $display("FAIL lat_after_redirect got %h/%h exp %h/%h", bus.PC_Current, bus.Instruction, e.pc, e.insn); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL lat_timeout left %0d exp 0", exp_q.size()); else passed++;
  endtask

  task automatic test_redirect_ack;
    rst = 1'b1; lat = 0; ready = 1'b0; br = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({bus.Insn_Valid, bus.Mem_Ack} !== 2'b11) $display("FAIL ack_precond got %b exp 11", {bus.Insn_Valid, bus.Mem_Ack}); else passed++;
    br = 1'b1; br_pc = 32'h203;
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (bus.Insn_Valid !== 1'b0) $display("FAIL ack_flush got %0b exp 0", bus.Insn_Valid); else passed++;
    checks++; if ({bus.Mem_Req, bus.Mem_Addr} !== {1'b1, 32'h200}) $display("FAIL ack_next_addr got %b/%h exp 1/00000200", bus.Mem_Req, bus.Mem_Addr); else passed++;
    exp_q.delete();
    exp_q.push_back({32'h200, 32'h03020100});
    exp_q.push_back({32'h204, 32'h07060504});
    exp_q.push_back({32'h208, 32'h0B0A0908});
    ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.Insn_Valid) begin
        e = exp_q.pop_front();
        checks++; if ({bus.PC_Current, bus.Instruction} !== {e.pc, e.insn}) $display("FAIL ack_stream got %h/%h exp %h/%h", bus.PC_Current, bus.Instruction, e.pc, e.insn); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL ack_timeout left %0d exp 0", exp_q.size()); else passed++;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf;
    rst = 1'b1; lat = 0; ready = 1'b0; br = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({fetch_count, flush_count} !== 64'h0) $display("FAIL perf_reset got %0d/%0d exp 0/0", fetch_count, flush_count); else passed++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    br = 1'b1; br_pc = 32'h40;
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd5) $display("FAIL perf_fetch got %0d exp 5", fetch_count); else passed++;
    checks++; if (flush_count !== 32'd1) $display("FAIL perf_flush got %0d exp 1", flush_count); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_ack();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised SimpleRisc instruction-fetch stage with a DEPTH-entry prefetch queue.
- Connects to a handshaked, byte-addressed instruction memory port.
- Decouples fetch from decode stalls and redirects cleanly on taken branches: queue flushed, stale in-flight response discarded.
- Sits between instruction memory and the decode stage; drives Instruction and PC_Current to decode.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSN_W, 32, instruction width in bits. Multiple of 8. PC step = INSN_W/8 bytes.
- DEPTH, 4, prefetch queue entries. Power of 2, >=2.
- RESET_PC, 0, fetch address after reset.

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Branch_PC  in  ADDR_W  redirect target.
- IsBranchTaken  in  1  redirect strobe, sampled each rising edge.
- Insn_Ready  in  1  decode accepts head entry this cycle.
- Insn_Valid  out  1  queue head valid.
- Instruction  out  INSN_W  head instruction.
- PC_Current  out  ADDR_W  head instruction address.
- Mem_Req  out  1  fetch request, registered.
- Mem_Addr  out  ADDR_W  fetch address, registered.
- Mem_Ack  in  1  memory accepted request; Mem_RData valid this cycle.
- Mem_RData  in  INSN_W  fetched bytes, little-endian: byte at Mem_Addr in bits [7:0].

Behaviour:
Reset values:
- Mem_Req=0, Mem_Addr=RESET_PC, Insn_Valid=0, Instruction=0, PC_Current=0.
- Queue empty; Fetch_PC=RESET_PC; state IDLE.
- Reset mid-operation drops Mem_Req immediately. Memory must tolerate an abandoned request.

Queue:
- Circular buffer of {PC, insn}, log2(DEPTH)-bit read/write pointers with wrap, count 0..DEPTH.
- Insn_Valid = (count != 0). Head outputs come straight from storage.
- Pop when Insn_Valid & Insn_Ready & !IsBranchTaken.
- Push on an accepted, non-discarded Mem_Ack.
- Push and pop in the same cycle: count unchanged.

States:
- IDLE: issue (Mem_Req<=1, Mem_Addr<=Fetch_PC, go REQ) when free slots after this edge > 0.
- REQ: Mem_Req and Mem_Addr held stable until Mem_Ack.
  - On Ack: push, Fetch_PC += INSN_W/8 (wraps modulo 2^ADDR_W).
  - If space remains after push/pop, reissue the next address back-to-back (stay REQ). Otherwise Mem_Req<=0, go IDLE.
  - Zero-wait memory sustains 1 insn/cycle.
- DISCARD: request outstanding after a redirect. Mem_Req held until Mem_Ack; data dropped, no push. Then issue from Fetch_PC (go REQ).

Redirect (IsBranchTaken=1 at an edge):
- Queue flushed, count<=0, no pop that cycle.
- Fetch_PC<=Branch_PC with low log2(INSN_W/8) bits cleared.
- IDLE: go REQ at Branch_PC on this edge.
- REQ without Ack: go DISCARD.
- REQ with Ack in the same cycle: data dropped, Mem_Req<=1 at Branch_PC (go REQ).
- DISCARD without Ack: target updated, stay DISCARD. Last redirect wins.
- Redirect-to-Insn_Valid with zero-wait memory: 2 cycles.

Fixed rules:
- At most one outstanding request.
- Only IsBranchTaken changes order; no speculation beyond sequential fetch.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds outputs Fetch_Count (32) and Flush_Count (32), both reset to 0.
  - Fetch_Count increments on each push.
  - Flush_Count increments once per redirect edge, counted whether or not entries are discarded.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. Reset asserted asynchronously mid-REQ -> Mem_Req=0, Insn_Valid=0 immediately; after release, first Mem_Addr=0x0.
2. Zero-wait memory, Insn_Ready=1, memory bytes 00..0F -> Instruction 0x03020100, 0x07060504, 0x0B0A0908 on consecutive cycles; PC_Current 0, 4, 8.
3. Insn_Ready=0, zero-wait memory -> exactly 4 pushes, Mem_Req=0, Mem_Addr last 0xC, head stays 0x0. Raise Insn_Ready -> fetch resumes at 0x10.
4. 3-cycle-latency memory, redirect to 0x100 one cycle after request at 0x8 -> response for 0x8 dropped; next Mem_Addr=0x100; first valid PC_Current=0x100.
5. Redirect to 0x203 coincident with Mem_Ack -> data dropped, queue empty, next Mem_Addr=0x200.
6. With IF_PERF_CNT_EN: 5 fetches then one redirect -> Fetch_Count=5, Flush_Count=1.
